// File: rtl/reg_bank_hs.sv
// rtl/reg_bank_hs.sv - control/status register bank with ack/err handshake, write protect, byte lanes and irq
//
// Purpose:
//   NUM_REGS 32-bit words at a 4-byte stride. Each word is RW, RO (driven by
//   hw_rdat) or W1C (sticky bits set by hw_set, cleared by writing ones).
//   Every accepted strobe gets exactly one reg_ack pulse on the following
//   cycle, carrying reg_rdat and reg_err.
//
// Ports:
//   reg_clk, reg_rstn   clock, synchronous active-low reset
//   wp_dis              1 = words in WP_MASK may be written
//   reg_wr, reg_rd      single-cycle access strobes
//   reg_we              byte enables for writes
//   reg_addr            byte address
//   reg_wdat            write data
//   reg_rdat            read data, qualified by reg_ack
//   reg_ack             one-cycle response pulse
//   reg_err             error flag, qualified by reg_ack
//   reg_ovr             sticky: strobe arrived while a response was pending
//   hw_rdat             RO word sources, word i at [32*i+:32]
//   hw_set              W1C per-bit set pulses, word i at [32*i+:32]
//   reg_q               current word values (RO words show hw_rdat)
//   irq                 registered OR of all W1C bits

module reg_bank_hs #(
  parameter int                     ADDR_WIDTH = 24,
  parameter int                     NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]    RW_MASK    = '1,
  parameter logic [NUM_REGS-1:0]    W1C_MASK   = '0,
  parameter logic [NUM_REGS-1:0]    WP_MASK    = '0,
  parameter logic [NUM_REGS*32-1:0] RST_VAL    = '0
) (
  input  logic                     reg_clk,
  input  logic                     reg_rstn,
  input  logic                     wp_dis,
  input  logic                     reg_wr,
  input  logic                     reg_rd,
  input  logic [3:0]               reg_we,
  input  logic [ADDR_WIDTH-1:0]    reg_addr,
  input  logic [31:0]              reg_wdat,
  output logic [31:0]              reg_rdat,
  output logic                     reg_ack,
  output logic                     reg_err,
  output logic                     reg_ovr,
  input  logic [NUM_REGS*32-1:0]   hw_rdat,
  input  logic [NUM_REGS*32-1:0]   hw_set,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic                     irq
);

  localparam int AW = ADDR_WIDTH - 2;

  // W1C overrides RW; anything that is neither is read-only.
  localparam logic [NUM_REGS-1:0] RO_MASK = ~(RW_MASK | W1C_MASK);

  typedef enum logic {IDLE, RESP} state_t;
  state_t state;

  logic [AW-1:0]       word_addr;
  logic [NUM_REGS-1:0] sel;
  logic                strobe;
  logic                dec_err;
  logic                wr_ok;
  logic [31:0]         lane;
  logic [31:0]         rd_word;
  logic                irq_next;

  assign word_addr = reg_addr[ADDR_WIDTH-1:2];
  assign strobe    = reg_wr | reg_rd;
  assign lane      = {{8{reg_we[3]}}, {8{reg_we[2]}}, {8{reg_we[1]}}, {8{reg_we[0]}}};

  // One-hot word select; an all-zero select means the index is out of range.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (word_addr == AW'(i));
    end
  end

  always_comb begin
    dec_err = (reg_wr & reg_rd)
            | (reg_addr[1:0] != 2'b00)
            | ~(|sel)
            | (reg_wr & (|(sel & RO_MASK)))
            | (reg_wr & (|(sel & WP_MASK)) & ~wp_dis);
  end

  // Only a strobe accepted in IDLE may modify state.
  assign wr_ok = (state == IDLE) & reg_wr & ~dec_err;

  // Read data comes from the current flop / hw_rdat values, i.e. before the
  // same-edge write or hw_set lands.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) rd_word = reg_q[32*i +: 32];
    end
  end

  always_comb begin
    irq_next = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) irq_next = irq_next | (|reg_q[32*i +: 32]);
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    if (W1C_MASK[i]) begin : g_w1c
      logic [31:0] q;
      logic [31:0] clr;
      assign clr = (wr_ok && sel[i]) ? (reg_wdat & lane) : 32'h0;
      // Set is applied after the clear so a same-cycle set wins.
      always_ff @(posedge reg_clk) begin
        if (!reg_rstn) q <= RST_VAL[32*i +: 32];
        else           q <= (q & ~clr) | hw_set[32*i +: 32];
      end
      assign reg_q[32*i +: 32] = q;
    end else if (RW_MASK[i]) begin : g_rw
      logic [31:0] q;
      always_ff @(posedge reg_clk) begin
        if (!reg_rstn)              q <= RST_VAL[32*i +: 32];
        else if (wr_ok && sel[i])   q <= (q & ~lane) | (reg_wdat & lane);
      end
      assign reg_q[32*i +: 32] = q;
    end else begin : g_ro
      assign reg_q[32*i +: 32] = hw_rdat[32*i +: 32];
    end
  end

  // hw_set only matters for W1C words and hw_rdat only for RO words.
  logic unused_ok;
  assign unused_ok = ^{hw_set, hw_rdat};

  always_ff @(posedge reg_clk) begin
    if (!reg_rstn) begin
      state    <= IDLE;
      reg_rdat <= '0;
      reg_ack  <= 1'b0;
      reg_err  <= 1'b0;
      reg_ovr  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= irq_next;
      case (state)
        IDLE: begin
          if (strobe) begin
            state    <= RESP;
            reg_ack  <= 1'b1;
            reg_err  <= dec_err;
            reg_rdat <= (reg_rd && !dec_err) ? rd_word : 32'h0;
          end else begin
            reg_ack  <= 1'b0;
            reg_err  <= 1'b0;
            reg_rdat <= '0;
          end
        end
        RESP: begin
          state    <= IDLE;
          reg_ack  <= 1'b0;
          reg_err  <= 1'b0;
          reg_rdat <= '0;
          // A strobe here is dropped without response.
          if (strobe) reg_ovr <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_hs.sv
// tb/tb_reg_bank_hs.sv - self-checking bench for reg_bank_hs
module tb_reg_bank_hs;

  localparam logic [255:0] P_RST = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0,
                                    32'h0, 32'h0, 32'h0, 32'h000000A5};

  logic         clk = 1'b0;
  logic         rstn;
  logic         wp_dis;
  logic         wr, rd;
  logic [3:0]   we;
  logic [23:0]  addr;
  logic [31:0]  wdat;
  logic [31:0]  rdat;
  logic         ack, err, ovr, irq;
  logic [255:0] hw_rdat, hw_set, q;

  always #5 clk = ~clk;

  reg_bank_hs #(
    .ADDR_WIDTH(24),
    .NUM_REGS  (8),
    .RW_MASK   (8'b1111_0111),
    .W1C_MASK  (8'b0000_0100),
    .WP_MASK   (8'b0001_0000),
    .RST_VAL   (P_RST)
  ) dut (
    .reg_clk (clk),
    .reg_rstn(rstn),
    .wp_dis  (wp_dis),
    .reg_wr  (wr),
    .reg_rd  (rd),
    .reg_we  (we),
    .reg_addr(addr),
    .reg_wdat(wdat),
    .reg_rdat(rdat),
    .reg_ack (ack),
    .reg_err (err),
    .reg_ovr (ovr),
    .hw_rdat (hw_rdat),
    .hw_set  (hw_set),
    .reg_q   (q),
    .irq     (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  we;
    logic [23:0] addr;
    logic [31:0] wdat;
    logic        wp;
    logic        err;
    logic [31:0] rdat;
    string       name;
  } vec_t;

  vec_t v[20];

  initial begin
    v[0]  = '{1'b0, 1'b1, 4'hF, 24'h000000, 32'h0,        1'b0, 1'b0, 32'h000000A5, "rd_w0_rst"};
    v[1]  = '{1'b1, 1'b0, 4'h5, 24'h000004, 32'h11223344, 1'b0, 1'b0, 32'h0,        "wr_w1_lanes"};
    v[2]  = '{1'b0, 1'b1, 4'hF, 24'h000004, 32'h0,        1'b0, 1'b0, 32'h00220044, "rd_w1_lanes"};
    v[3]  = '{1'b1, 1'b0, 4'h0, 24'h000004, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0,        "wr_w1_we0"};
    v[4]  = '{1'b0, 1'b1, 4'hF, 24'h000004, 32'h0,        1'b0, 1'b0, 32'h00220044, "rd_w1_we0"};
    v[5]  = '{1'b0, 1'b1, 4'hF, 24'h00000C, 32'h0,        1'b0, 1'b0, 32'h0BADF00D, "rd_ro"};
    v[6]  = '{1'b1, 1'b0, 4'hF, 24'h00000C, 32'h12345678, 1'b0, 1'b1, 32'h0,        "wr_ro"};
    v[7]  = '{1'b1, 1'b0, 4'hF, 24'h000010, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        "wr_wp_on"};
    v[8]  = '{1'b0, 1'b1, 4'hF, 24'h000010, 32'h0,        1'b0, 1'b0, 32'h0,        "rd_wp_on"};
    v[9]  = '{1'b1, 1'b0, 4'hF, 24'h000010, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        "wr_wp_off"};
    v[10] = '{1'b0, 1'b1, 4'hF, 24'h000010, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF, "rd_wp_off"};
    v[11] = '{1'b0, 1'b1, 4'hF, 24'h000002, 32'h0,        1'b0, 1'b1, 32'h0,        "rd_misalign"};
    v[12] = '{1'b0, 1'b1, 4'hF, 24'h000020, 32'h0,        1'b0, 1'b1, 32'h0,        "rd_oor"};
    v[13] = '{1'b1, 1'b1, 4'hF, 24'h000000, 32'h5555AAAA, 1'b0, 1'b1, 32'h0,        "wr_rd_both"};
    v[14] = '{1'b0, 1'b1, 4'hF, 24'h000000, 32'h0,        1'b0, 1'b0, 32'h000000A5, "rd_w0_after_both"};
    v[15] = '{1'b1, 1'b0, 4'hF, 24'h000001, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        "wr_misalign"};
    v[16] = '{1'b0, 1'b1, 4'hF, 24'h000014, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, "rd_w5_rst"};
    v[17] = '{1'b1, 1'b0, 4'h8, 24'h000014, 32'h01020304, 1'b0, 1'b0, 32'h0,        "wr_w5_lane3"};
    v[18] = '{1'b0, 1'b1, 4'hF, 24'h000014, 32'h0,        1'b0, 1'b0, 32'h01ADBEEF, "rd_w5_lane3"};
    v[19] = '{1'b1, 1'b0, 4'hF, 24'h000104, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        "wr_far_oor"};
  end

  initial begin
    rstn    = 1'b0;
    wp_dis  = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    we      = 4'h0;
    addr    = '0;
    wdat    = '0;
    hw_set  = '0;
    hw_rdat = {8{32'h5A5A5A5A}};
    hw_rdat[96 +: 32] = 32'h0BADF00D;

    repeat (2) @(posedge clk);
    #1;
    check("rst_w0",   q[31:0],      32'h000000A5);
    check("rst_w5",   q[160 +: 32], 32'hDEADBEEF);
    check("rst_ack",  {31'd0, ack}, 32'd0);
    check("rst_err",  {31'd0, err}, 32'd0);
    check("rst_irq",  {31'd0, irq}, 32'd0);
    check("rst_ovr",  {31'd0, ovr}, 32'd0);
    check("rst_rdat", rdat,         32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven single accesses
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wr = v[k].wr; rd = v[k].rd; we = v[k].we;
      addr = v[k].addr; wdat = v[k].wdat; wp_dis = v[k].wp;
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0;
      check({v[k].name, "_ack"},  {31'd0, ack}, 32'd1);
      check({v[k].name, "_err"},  {31'd0, err}, {31'd0, v[k].err});
      check({v[k].name, "_rdat"}, rdat,         v[k].rdat);
      @(posedge clk);
      #1;
      check({v[k].name, "_ack_low"}, {31'd0, ack}, 32'd0);
    end
    wp_dis = 1'b0;
    check("wp_word_q", q[128 +: 32], 32'hFFFFFFFF);

    // W1C: hw_set pulse, irq one cycle after the bit appears
    @(negedge clk);
    hw_set[64 + 3] = 1'b1;
    @(posedge clk);
    #1;
    hw_set = '0;
    check("w1c_set_q",   q[64 +: 32],  32'h8);
    check("w1c_set_irq0", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("w1c_set_irq1", {31'd0, irq}, 32'd1);

    // Clear and set of the same bit in the same cycle: set wins
    @(negedge clk);
    hw_set[64 + 3] = 1'b1;
    wr = 1'b1; we = 4'hF; addr = 24'h8; wdat = 32'h8;
    @(posedge clk);
    #1;
    hw_set = '0; wr = 1'b0;
    check("w1c_race_ack", {31'd0, ack}, 32'd1);
    check("w1c_race_err", {31'd0, err}, 32'd0);
    check("w1c_race_q",   q[64 +: 32],  32'h8);
    @(posedge clk);

    // Plain clear: bit drops at N+1, irq one cycle later
    @(negedge clk);
    wr = 1'b1; we = 4'hF; addr = 24'h8; wdat = 32'h8;
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("w1c_clr_q",    q[64 +: 32],  32'h0);
    check("w1c_clr_irq1", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1;
    check("w1c_clr_irq0", {31'd0, irq}, 32'd0);

    // Overrun: back-to-back write strobes, second is dropped
    @(negedge clk);
    wr = 1'b1; we = 4'hF; addr = 24'h18; wdat = 32'h11111111;
    @(posedge clk);
    #1;
    wdat = 32'h22222222;
    check("ovr_ack1", {31'd0, ack}, 32'd1);
    check("ovr_ovr0", {31'd0, ovr}, 32'd0);
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("ovr_ack2", {31'd0, ack}, 32'd0);
    check("ovr_ovr1", {31'd0, ovr}, 32'd1);
    check("ovr_q",    q[192 +: 32], 32'h11111111);
    @(posedge clk);
    #1;
    check("ovr_ack3",   {31'd0, ack}, 32'd0);
    check("ovr_sticky", {31'd0, ovr}, 32'd1);

    // Reset asserted during RESP with irq pending
    @(negedge clk);
    hw_set[64] = 1'b1;
    @(posedge clk);
    #1;
    hw_set = '0;
    @(negedge clk);
    rd = 1'b1; addr = 24'h0;
    @(posedge clk);
    #1;
    rd = 1'b0;
    check("rresp_ack_pre", {31'd0, ack}, 32'd1);
    check("rresp_irq_pre", {31'd0, irq}, 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rresp_ack",  {31'd0, ack}, 32'd0);
    check("rresp_err",  {31'd0, err}, 32'd0);
    check("rresp_rdat", rdat,         32'd0);
    check("rresp_ovr",  {31'd0, ovr}, 32'd0);
    check("rresp_irq",  {31'd0, irq}, 32'd0);
    check("rresp_w6",   q[192 +: 32], 32'h0);
    check("rresp_w2",   q[64 +: 32],  32'h0);

    // Strobe while reset is held: dropped, no ack
    @(negedge clk);
    wr = 1'b1; we = 4'hF; addr = 24'h4; wdat = 32'hFFFF0000;
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("rstrb_ack", {31'd0, ack}, 32'd0);
    check("rstrb_w1",  q[32 +: 32],  32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rstrb_ack_after", {31'd0, ack}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
